// File: rtl/poly1305_pkg.sv
// Shared widths, the Poly1305 prime and the reduction state encoding.
// Intermediate widths are derived from the fold bounds so that no carry can be lost.
package poly1305_pkg;

  localparam int P_W = 259;
  localparam int H_W = 130;

  localparam logic [H_W-1:0] PRIME = 130'h3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB;

  // Width of lo + 5*hi: 5*hi needs hi_w+3 bits, and the add may carry one more.
  function automatic int fold_sum_w(input int lo_w, input int hi_w);
    return ((hi_w + 3 > lo_w) ? hi_w + 3 : lo_w) + 1;
  endfunction

  localparam int T1_W = fold_sum_w(H_W, P_W - H_W);
  localparam int T2_W = fold_sum_w(H_W, T1_W - H_W);

  typedef enum logic [1:0] {
    IDLE,
    FOLD1,
    FOLD2,
    FINAL
  } red_state_t;

endpackage

// File: rtl/poly1305_fold5.sv
// Combinational fold lo + 5*hi, using 2^130 == 5 (mod p); 5*hi is formed as (hi<<2)+hi.
module poly1305_fold5
  import poly1305_pkg::*;
#(
  parameter int LO_W  = 130,
  parameter int HI_W  = 129,
  parameter int SUM_W = fold_sum_w(LO_W, HI_W)
) (
  input  logic [LO_W-1:0]  lo,
  input  logic [HI_W-1:0]  hi,
  output logic [SUM_W-1:0] sum
);

  logic [HI_W+2:0] five_hi;

  assign five_hi = {1'b0, hi, 2'b00} + {3'b000, hi};
  assign sum     = SUM_W'(lo) + SUM_W'(five_hi);

endmodule

// File: rtl/poly1305_reduce.sv
// Reduces the 259-bit multiplier product modulo 2^130-5 in three steps:
// two 5x folds followed by one conditional subtract, with a ready pulse.
module poly1305_reduce
  import poly1305_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] P,
  output logic [H_W-1:0] H,
  output logic           ready,
  output logic           busy
);

  red_state_t state;
  red_state_t state_next;

  logic [P_W-1:0]  p_reg;
  logic [T1_W-1:0] t1;
  logic [T2_W-1:0] t2;
  logic [T1_W-1:0] fold1_sum;
  logic [T2_W-1:0] fold2_sum;
  logic            t2_ge_p;
  logic [T2_W-1:0] t2_sub;
  logic [H_W-1:0]  h_next;

  poly1305_fold5 #(
    .LO_W (H_W),
    .HI_W (P_W - H_W)
  ) u_fold1 (
    .lo  (p_reg[H_W-1:0]),
    .hi  (p_reg[P_W-1:H_W]),
    .sum (fold1_sum)
  );

  poly1305_fold5 #(
    .LO_W (H_W),
    .HI_W (T1_W - H_W)
  ) u_fold2 (
    .lo  (t1[H_W-1:0]),
    .hi  (t1[T1_W-1:H_W]),
    .sum (fold2_sum)
  );

  // t2 < 2^130 + 35, so a single subtract of p always lands in [0, p-1].
  assign t2_ge_p = (t2 >= T2_W'(PRIME));
  assign t2_sub  = t2 - T2_W'(PRIME);
  assign h_next  = t2_ge_p ? t2_sub[H_W-1:0] : t2[H_W-1:0];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start in any state restarts from FOLD1 with the new product.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) begin
      state_next = FOLD1;
    end
  end

  // FINAL still completes when a new start lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg <= '0;
      t1    <= '0;
      t2    <= '0;
      H     <= '0;
      ready <= 1'b0;
    end else begin
      ready <= (state == FINAL);
      case (state)
        FOLD1:   t1 <= fold1_sum;
        FOLD2:   t2 <= fold2_sum;
        FINAL:   H  <= h_next;
        default: ;
      endcase
      if (start) begin
        p_reg <= P;
      end
    end
  end

endmodule

// File: tb/tb_poly1305_reduce.sv
// Scoreboard bench for poly1305_reduce: expected results are queued at start and
// popped whenever ready is seen; directed corner cases plus random back-to-back traffic.
module tb_poly1305_reduce;
  import poly1305_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [P_W-1:0] P;
  logic [H_W-1:0] H;
  logic           ready;
  logic           busy;

  int tests     = 0;
  int fails     = 0;
  int ready_cnt = 0;
  logic [H_W-1:0] exp_q[$];

  poly1305_reduce dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .P     (P),
    .H     (H),
    .ready (ready),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [H_W-1:0] ref_mod(input logic [P_W-1:0] x);
    logic [P_W-1:0] m;
    logic [P_W-1:0] r;
    m = {{(P_W-H_W){1'b0}}, PRIME};
    r = x % m;
    return r[H_W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [H_W-1:0] obs, input logic [H_W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller must be #1 after a rising edge; returns #1 after the capture edge.
  task automatic applyStimulus(input logic [P_W-1:0] pv, input logic [H_W-1:0] expv, input bit track);
    start = 1'b1;
    P     = pv;
    if (track) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput(tag, H_W'(exp_q.size()), '0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL ready_unexpected observed_H=%h expected=no ready pulse", H);
      end
      if (exp_q.size() != 0) checkOutput("result_H", H, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [P_W-1:0] one;
    logic [P_W-1:0] rp;
    logic [287:0]   raw;
    int busy_cnt;
    int ready_at;
    int rc0;

    one   = 259'd1;
    rst   = 1'b1;
    start = 1'b0;
    P     = '0;

    @(negedge clk);
    checkOutput("reset_H", H, '0);
    checkOutput("reset_ready", H_W'(ready), '0);
    checkOutput("reset_busy", H_W'(busy), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero product: latency and busy window.
    applyStimulus('0, '0, 1'b1);
    busy_cnt = 0;
    ready_at = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (ready === 1'b1) ready_at = k;
    end
    checkOutput("busy_cycles", H_W'(busy_cnt), H_W'(3));
    checkOutput("ready_latency", H_W'(ready_at), H_W'(4));
    waitDrain("drain_zero");

    // Directed boundary values.
    applyStimulus({129'd0, PRIME}, '0, 1'b1);
    waitDrain("drain_p");
    applyStimulus((one << 130) - 259'd2, 130'd3, 1'b1);
    waitDrain("drain_p_plus3");
    applyStimulus((one << 131) - 259'd10, '0, 1'b1);
    waitDrain("drain_2p");
    applyStimulus(one << 130, 130'd5, 1'b1);
    waitDrain("drain_2pow130");
    applyStimulus(one << 258, (130'd1 << 128) + 130'd5, 1'b1);
    waitDrain("drain_2pow258");
    applyStimulus({P_W{1'b1}}, (130'd1 << 129) + 130'd9, 1'b1);
    waitDrain("drain_all_ones");

    // Second start on the FINAL edge, then random back-to-back on the ready cycle.
    applyStimulus(one << 130, 130'd5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(259'd123456789, 130'd123456789, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 1000; n++) begin
      raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      rp = raw[P_W-1:0];
      if (n % 8 == 0) rp[P_W-1:P_W-40] = '1;
      if (n % 8 == 1) rp = {129'd0, PRIME} + 259'(n % 6);
      applyStimulus(rp, ref_mod(rp), 1'b1);
      repeat (3) @(posedge clk);
      #1;
    end
    waitDrain("drain_random");

    // Restart one cycle after a start: only the second result appears.
    rc0 = ready_cnt;
    applyStimulus(one << 130, 130'd5, 1'b0);
    applyStimulus(259'd7, 130'd7, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("restart_pulses", H_W'(ready_cnt - rc0), H_W'(1));
    waitDrain("drain_restart");

    // Reset during FOLD2.
    applyStimulus(one << 130, 130'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", H_W'(busy), '0);
    checkOutput("rst_H", H, '0);
    @(negedge clk);
    rst = 1'b0;
    rc0 = ready_cnt;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_no_ready", H_W'(ready_cnt - rc0), '0);
    checkOutput("rst_H_hold", H, '0);
    applyStimulus(259'd12, 130'd12, 1'b1);
    waitDrain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
